fas_pack_stage: RTL and testbench
=================================

// Module: fas_pack_stage
// PURPOSE
//  Final stage of the float add/sub pipeline: consumes the rounded {sign, significand32} word and base
//  exponent from the rounding stage, normalizes (leading-zero count + shift), computes the final
//  exponent, applies overflow/underflow rules and packs an IEEE-754 single. Keeps sticky exception
//  flags and a result counter for the status block. Fixed 2-cycle latency, no backpressure.
// PARAMETERS
//  CNT_W   16   width of saturating result counter
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst_n      in   1   synchronous reset, active-low
//  x3         in   33  [32]=sign, [31:0]=rounded significand (bit31 carry, bit30 hidden-1 position)
//  base_ei    in   9   unsigned biased exponent of the value whose hidden 1 sits at bit30
//  enable     in   1   x3/base_ei valid this cycle (one result per enable cycle)
//  result     out  32  packed IEEE-754 single
//  valid      out  1   result valid, single-cycle pulse per accepted input
//  ovf        out  1   this result overflowed (qualified by valid)
//  unf        out  1   this result underflowed/flushed (qualified by valid)
//  zero       out  1   significand input was zero (qualified by valid)
//  flag_clr   in   1   clear sticky flags and counter
//  sticky_ovf out  1   set by any ovf result until flag_clr
//  sticky_unf out  1   set by any unf result until flag_clr
//  result_cnt out  CNT_W  count of valid results, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): every output and internal register = 0; in-flight results discarded.
//  - Stage A (cycle 1): on enable register sign, sig, base_e, lz = leading zeros of sig (0..32),
//    vA<=enable. When enable=0, data registers hold; vA<=0.
//  - Stage B (cycle 2): n = sig << lz (5-bit shift; lz=32 only when sig=0);
//    e = base_e + 1 - lz, signed 11-bit; frac = n[30:8] (n[7:0] discarded, rounding already done).
//  - Pack priority: sig==0 -> {sign,31'h0}, zero=1; else e>=255 -> {sign,8'hFF,23'h0}, ovf=1;
//    else e<=0 -> {sign,31'h0} (denormals flushed), unf=1; else {sign,e[7:0],frac}.
//  - valid asserts exactly 2 cycles after the enable cycle; back-to-back enables give back-to-back
//    valids. result/ovf/unf/zero update only when vA=1, otherwise hold; ovf/unf/zero meaningful only
//    with valid.
//  - Sticky: set on valid&ovf / valid&unf; flag_clr clears next edge; same-cycle clr and set -> set
//    wins (event not lost). result_cnt += valid, saturates; clr with valid same cycle -> cnt = 1.
//  - Reset mid-operation: both stages flushed; no valid emitted for inputs accepted before reset.
// STRUCTURE
//  - Shared include fas_defs.vh: FAS_EXP_INF=8'hFF, FAS_EXP_W=8, FAS_FRAC_W=23, FAS_SIG_W=32, SIG_HIDDEN=30.
//  - One sub-module: fas_lzc32 (combinational 32-bit leading-zero count, 6-bit out, 32 for zero),
//    instantiated in stage A; shift/exponent/pack logic inline in stage B.
// TESTING
//  - sign0, sig=0x4000_0000, base=127, enable 1 cycle -> result=0x3F80_0000, valid at +2, flags 0.
//  - sig=0x8000_0000 (rounding carry), base=127 -> 0x4000_0000; sig=0x1000_0000, base=127 -> 0x3E80_0000.
//  - sig=0x8000_0000, base=254 -> 0x7F80_0000, ovf=1, sticky_ovf=1; sign1 -> 0xFF80_0000.
//  - sign1, sig=0x2000_0000, base=1 (e=0) -> 0x8000_0000, unf=1; sig=0, base=200 -> {sign,31'h0}, zero=1, unf=0.
//  - 4 back-to-back enables -> 4 consecutive valids in order, result_cnt=4; flag_clr coincident with
//    an ovf result -> sticky_ovf stays 1, result_cnt=1.
//  - enable, then rst_n=0 next cycle -> no valid appears, all outputs 0; enable after reset -> normal latency 2.

Source files
------------

// File: rtl/fas_pack_stage_pkg.sv
// Shared constants and types for the float add/sub pack stage.
// Holds the IEEE-754 single field geometry and the stage-A pipeline word.
package fas_pack_stage_pkg;

   localparam logic [7:0] FAS_EXP_INF = 8'hFF;
   localparam int FAS_EXP_W  = 8;
   localparam int FAS_FRAC_W = 23;
   localparam int FAS_SIG_W  = 32;
   localparam int SIG_HIDDEN = 30;

   typedef struct packed {
      logic                 sign;
      logic [FAS_SIG_W-1:0] sig;
      logic [8:0]           base_e;
      logic [5:0]           lz;
   } stage_a_t;

   typedef enum logic [1:0] {
      PACK_NORM,
      PACK_ZERO,
      PACK_OVF,
      PACK_UNF
   } pack_kind_t;

   // Zero input wins over exponent range; overflow is tested before underflow.
   function automatic pack_kind_t classify(input logic sig_zero, input logic signed [10:0] e);
      if (sig_zero)            return PACK_ZERO;
      else if (e >= 11'sd255)  return PACK_OVF;
      else if (e <= 11'sd0)    return PACK_UNF;
      else                     return PACK_NORM;
   endfunction

endpackage

// File: rtl/fas_lzc32.sv
// Combinational 32-bit leading-zero count; returns 32 when the input is zero.
module fas_lzc32
   import fas_pack_stage_pkg::*;
(
   input  logic [FAS_SIG_W-1:0] sig,
   output logic [5:0]           lz
);

   always_comb begin
      // NOTE: default assigned first so every path drives lz and no latch is inferred.
      lz = 6'd32;
      // Ascending scan: the most significant set bit is the last to write lz.
      for (int i = 0; i < FAS_SIG_W; i++) begin
         if (sig[i]) lz = 6'(FAS_SIG_W - 1 - i);
      end
   end

endmodule

// File: rtl/fas_pack_stage.sv
// Final add/sub stage: normalize, compute exponent, apply ovf/unf rules, pack single.
// Two-cycle latency with sticky exception flags and a saturating result counter.
module fas_pack_stage
   import fas_pack_stage_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [32:0]      x3,
   input  logic [8:0]       base_ei,
   input  logic             enable,
   output logic [31:0]      result,
   output logic             valid,
   output logic             ovf,
   output logic             unf,
   output logic             zero,
   input  logic             flag_clr,
   output logic             sticky_ovf,
   output logic             sticky_unf,
   output logic [CNT_W-1:0] result_cnt
);

   stage_a_t   a_q;
   logic       v_a;
   logic [5:0] lz_in;

   fas_lzc32 u_lzc (
      .sig (x3[FAS_SIG_W-1:0]),
      .lz  (lz_in)
   );

   logic [FAS_SIG_W-1:0]  n;
   logic signed [10:0]    e;
   logic [FAS_FRAC_W-1:0] frac;
   pack_kind_t            kind;
   logic [31:0]           packed_word;

   always_comb begin
      n    = a_q.sig << a_q.lz[4:0];
      e    = $signed({2'b00, a_q.base_e}) + 11'sd1 - $signed({5'b00000, a_q.lz});
      // Dropping bit31 (the leading 1) and the low byte leaves exactly n[30:8].
      frac = FAS_FRAC_W'(n >> (SIG_HIDDEN + 1 - FAS_FRAC_W));
      kind = classify(a_q.sig == '0, e);
      unique case (kind)
         PACK_ZERO: packed_word = {a_q.sign, 31'h0};
         PACK_OVF:  packed_word = {a_q.sign, FAS_EXP_INF, {FAS_FRAC_W{1'b0}}};
         PACK_UNF:  packed_word = {a_q.sign, 31'h0};
         default:   packed_word = {a_q.sign, e[FAS_EXP_W-1:0], frac};
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: every register, data included, is cleared so reset flushes both stages.
      if (!rst_n) begin
         a_q    <= '0;
         v_a    <= 1'b0;
         result <= '0;
         valid  <= 1'b0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         // NOTE: non-blocking so stage B reads the previous stage-A contents.
         v_a   <= enable;
         valid <= v_a;
         if (enable) a_q <= '{sign: x3[32], sig: x3[FAS_SIG_W-1:0], base_e: base_ei, lz: lz_in};
         if (v_a) begin
            result <= packed_word;
            ovf    <= (kind == PACK_OVF);
            unf    <= (kind == PACK_UNF);
            zero   <= (kind == PACK_ZERO);
         end
      end
   end

   // Status: a set event in the clearing cycle survives the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
         result_cnt <= '0;
      end else begin
         if (valid && ovf)  sticky_ovf <= 1'b1;
         else if (flag_clr) sticky_ovf <= 1'b0;
         if (valid && unf)  sticky_unf <= 1'b1;
         else if (flag_clr) sticky_unf <= 1'b0;
         if (flag_clr)                        result_cnt <= valid ? CNT_W'(1) : '0;
         else if (valid && result_cnt != '1)  result_cnt <= result_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fas_pack_stage.sv
// Directed self-checking bench for fas_pack_stage; expected words computed by hand.
module tb_fas_pack_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [32:0] x3;
   logic [8:0]  base_ei;
   logic        enable;
   logic [31:0] result;
   logic        valid, ovf, unf, zero;
   logic        flag_clr;
   logic        sticky_ovf, sticky_unf;
   logic [15:0] result_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   fas_pack_stage #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x3         (x3),
      .base_ei    (base_ei),
      .enable     (enable),
      .result     (result),
      .valid      (valid),
      .ovf        (ovf),
      .unf        (unf),
      .zero       (zero),
      .flag_clr   (flag_clr),
      .sticky_ovf (sticky_ovf),
      .sticky_unf (sticky_unf),
      .result_cnt (result_cnt)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic drive_one(input logic s, input logic [31:0] sg, input logic [8:0] b,
                            output logic v1, output logic v2, output logic [31:0] r,
                            output logic o, output logic u, output logic z);
      @(negedge clk);
      x3 = {s, sg}; base_ei = b; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0; v1 = valid;
      @(negedge clk);
      v2 = valid; r = result; o = ovf; u = unf; z = zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; flag_clr = 1'b0; x3 = '0; base_ei = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({result, valid, ovf, unf, zero, sticky_ovf, sticky_unf, result_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got res=%h v=%b o=%b u=%b z=%b so=%b su=%b cnt=%0d, want all 0",
                  result, valid, ovf, unf, zero, sticky_ovf, sticky_unf, result_cnt);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      logic v1, v2, o, u, z; logic [31:0] r;
      logic [31:0] sigs [3] = '{32'h4000_0000, 32'h8000_0000, 32'h1000_0000};
      logic [31:0] exps [3] = '{32'h3F80_0000, 32'h4000_0000, 32'h3E80_0000};
      for (int i = 0; i < 3; i++) begin
         drive_one(1'b0, sigs[i], 9'd127, v1, v2, r, o, u, z);
         tests_run++;
         if (v1 !== 1'b0 || v2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_latency[%0d]: valid at +1=%b +2=%b, want 0 1", i, v1, v2);
         end
         tests_run++;
         if (r !== exps[i] || {o, u, z} !== 3'b000) begin
            tests_failed++;
            $display("FAIL normal_result[%0d]: got %h ouz=%b, want %h ouz=000", i, r, {o, u, z}, exps[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic v1, v2, o, u, z; logic [31:0] r;
      drive_one(1'b0, 32'h8000_0000, 9'd254, v1, v2, r, o, u, z);
      tests_run++;
      if (v2 !== 1'b1 || r !== 32'h7F80_0000 || {o, u, z} !== 3'b100) begin
         tests_failed++;
         $display("FAIL ovf_pos: got v=%b %h ouz=%b, want v=1 7f800000 ouz=100", v2, r, {o, u, z});
      end
      @(negedge clk);
      tests_run++;
      if (sticky_ovf !== 1'b1 || sticky_unf !== 1'b0) begin
         tests_failed++;
         $display("FAIL sticky_ovf_set: got so=%b su=%b, want 1 0", sticky_ovf, sticky_unf);
      end
      drive_one(1'b1, 32'h8000_0000, 9'd254, v1, v2, r, o, u, z);
      tests_run++;
      if (r !== 32'hFF80_0000 || o !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_neg: got %h ovf=%b, want ff800000 ovf=1", r, o);
      end
   endtask

   task automatic test_underflow_zero();
      logic v1, v2, o, u, z; logic [31:0] r;
      drive_one(1'b1, 32'h2000_0000, 9'd1, v1, v2, r, o, u, z);
      tests_run++;
      if (r !== 32'h8000_0000 || {o, u, z} !== 3'b010) begin
         tests_failed++;
         $display("FAIL unf_flush: got %h ouz=%b, want 80000000 ouz=010", r, {o, u, z});
      end
      @(negedge clk);
      tests_run++;
      if (sticky_unf !== 1'b1) begin
         tests_failed++;
         $display("FAIL sticky_unf_set: got %b, want 1", sticky_unf);
      end
      drive_one(1'b1, 32'h0000_0000, 9'd200, v1, v2, r, o, u, z);
      tests_run++;
      if (r !== 32'h8000_0000 || {o, u, z} !== 3'b001) begin
         tests_failed++;
         $display("FAIL zero_input: got %h ouz=%b, want 80000000 ouz=001", r, {o, u, z});
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] sigs [4] = '{32'h4000_0000, 32'h8000_0000, 32'h1000_0000, 32'h6000_0000};
      logic [31:0] exps [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h3E80_0000, 32'h3FC0_0000};
      @(negedge clk); flag_clr = 1'b1;
      @(negedge clk); flag_clr = 1'b0;
      tests_run++;
      if (result_cnt !== 16'd0 || sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin
         tests_failed++;
         $display("FAIL flag_clr: got cnt=%0d so=%b su=%b, want 0 0 0", result_cnt, sticky_ovf, sticky_unf);
      end
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         if (k >= 2) begin
            tests_run++;
            if (valid !== 1'b1 || result !== exps[k-2]) begin
               tests_failed++;
               $display("FAIL b2b[%0d]: got v=%b %h, want v=1 %h", k - 2, valid, result, exps[k-2]);
            end
         end
         if (k < 4) begin
            x3 = {1'b0, sigs[k]}; base_ei = 9'd127; enable = 1'b1;
         end else begin
            enable = 1'b0;
         end
      end
      @(negedge clk);
      tests_run++;
      if (valid !== 1'b0 || result_cnt !== 16'd4) begin
         tests_failed++;
         $display("FAIL b2b_count: got v=%b cnt=%0d, want v=0 cnt=4", valid, result_cnt);
      end
   endtask

   task automatic test_clr_collision();
      @(negedge clk);
      x3 = {1'b0, 32'h8000_0000}; base_ei = 9'd254; enable = 1'b1;
      @(negedge clk); enable = 1'b0;
      @(negedge clk); flag_clr = 1'b1;
      tests_run++;
      if (valid !== 1'b1 || ovf !== 1'b1) begin
         tests_failed++;
         $display("FAIL clr_coll_result: got v=%b ovf=%b, want 1 1", valid, ovf);
      end
      @(negedge clk); flag_clr = 1'b0;
      tests_run++;
      if (sticky_ovf !== 1'b1 || sticky_unf !== 1'b0 || result_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL clr_coll_status: got so=%b su=%b cnt=%0d, want 1 0 1", sticky_ovf, sticky_unf, result_cnt);
      end
   endtask

   task automatic test_reset_mid_op();
      logic seen = 1'b0;
      logic v1, v2, o, u, z; logic [31:0] r;
      @(negedge clk);
      x3 = {1'b0, 32'h4000_0000}; base_ei = 9'd127; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      if (valid) seen = 1'b1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (valid) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_flush_valid: got valid seen=%b, want 0", seen);
      end
      tests_run++;
      if ({result, ovf, unf, zero, sticky_ovf, sticky_unf, result_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL rst_flush_outputs: got res=%h so=%b cnt=%0d, want all 0", result, sticky_ovf, result_cnt);
      end
      drive_one(1'b0, 32'h1000_0000, 9'd127, v1, v2, r, o, u, z);
      tests_run++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || r !== 32'h3E80_0000) begin
         tests_failed++;
         $display("FAIL post_reset: got v+1=%b v+2=%b %h, want 0 1 3e800000", v1, v2, r);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_overflow();
      test_underflow_zero();
      test_back_to_back();
      test_clr_collision();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
